// File: rtl/pinaipple_dma.sv
`default_nettype none
// ============================================================================
// Module   : pinaipple_dma
// Brief    : Single-outstanding word-copy DMA engine with a 4 KiB config port.
// Revision : 1.0
// ============================================================================
module pinaipple_dma #(
    parameter int CfgAddrWidth = 12,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    device_req_i,
    input  logic [CfgAddrWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [3:0]              device_be_i,
    input  logic [31:0]             device_wdata_i,
    output logic                    device_rvalid_o,
    output logic [31:0]             device_rdata_o,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [31:0]             req_tgt_addr_o,
    output logic                    req_wen_o,
    output logic [31:0]             req_wdata_o,
    output logic [3:0]              req_be_o,
    input  logic                    resp_valid_i,
    output logic                    resp_ready_o,
    input  logic [31:0]             resp_rdata_i,
    output logic                    irq_o
);

    localparam logic [CfgAddrWidth-1:0] OFS_SRC    = CfgAddrWidth'('h00);
    localparam logic [CfgAddrWidth-1:0] OFS_DST    = CfgAddrWidth'('h04);
    localparam logic [CfgAddrWidth-1:0] OFS_LEN    = CfgAddrWidth'('h08);
    localparam logic [CfgAddrWidth-1:0] OFS_CTRL   = CfgAddrWidth'('h0C);
    localparam logic [CfgAddrWidth-1:0] OFS_STATUS = CfgAddrWidth'('h10);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [31:0]          src_reg, dst_reg;
    logic [LenWidth-1:0]  len_reg;
    logic                 irq_en, done, aborted, abort_pend;
    logic [31:0]          src_w, dst_w, data_buf;
    logic [LenWidth-1:0]  cnt;

    logic                 busy, cfg_wr, cfg_rd;
    logic                 wr_src, wr_dst, wr_len, wr_ctrl, wr_status;
    logic                 start_cmd, abort_cmd, abort_hit;
    logic                 rd_capture, word_done, finish_done, finish_abort;
    logic [31:0]          rd_mux;

    assign busy      = (state != S_IDLE);
    assign cfg_wr    = device_req_i & device_we_i & (device_be_i == 4'hF);
    assign cfg_rd    = device_req_i & ~device_we_i;
    assign wr_src    = cfg_wr & (device_addr_i == OFS_SRC) & ~busy;
    assign wr_dst    = cfg_wr & (device_addr_i == OFS_DST) & ~busy;
    assign wr_len    = cfg_wr & (device_addr_i == OFS_LEN) & ~busy;
    assign wr_ctrl   = cfg_wr & (device_addr_i == OFS_CTRL);
    assign wr_status = cfg_wr & (device_addr_i == OFS_STATUS);
    assign start_cmd = wr_ctrl & device_wdata_i[0] & ~busy;
    assign abort_cmd = wr_ctrl & device_wdata_i[2] & busy;
    // An abort written in the same cycle as a response still stops the engine.
    assign abort_hit = abort_pend | abort_cmd;

    assign req_be_o  = 4'hF;
    assign irq_o     = done & irq_en;

    always_comb begin
        state_nx       = state;
        req_valid_o    = 1'b0;
        req_wen_o      = 1'b0;
        req_tgt_addr_o = 32'h0;
        req_wdata_o    = 32'h0;
        resp_ready_o   = 1'b0;
        rd_capture     = 1'b0;
        word_done      = 1'b0;
        finish_done    = 1'b0;
        finish_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_cmd && (len_reg != '0)) begin
                    state_nx = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                req_valid_o    = 1'b1;
                req_tgt_addr_o = src_w;
                if (req_ready_i) begin
                    state_nx = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                resp_ready_o = 1'b1;
                if (resp_valid_i) begin
                    rd_capture = 1'b1;
                    if (abort_hit) begin
                        state_nx     = S_IDLE;
                        finish_abort = 1'b1;
                    end else begin
                        state_nx = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                req_valid_o    = 1'b1;
                req_wen_o      = 1'b1;
                req_tgt_addr_o = dst_w;
                req_wdata_o    = data_buf;
                if (req_ready_i) begin
                    state_nx = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                resp_ready_o = 1'b1;
                if (resp_valid_i) begin
                    word_done = 1'b1;
                    if (abort_hit) begin
                        state_nx     = S_IDLE;
                        finish_abort = 1'b1;
                    end else if (cnt == LenWidth'(1)) begin
                        state_nx    = S_IDLE;
                        finish_done = 1'b1;
                    end else begin
                        state_nx = S_RD_REQ;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        case (device_addr_i)
            OFS_SRC:    rd_mux = src_reg;
            OFS_DST:    rd_mux = dst_reg;
            OFS_LEN:    rd_mux = {{(32-LenWidth){1'b0}}, len_reg};
            OFS_CTRL:   rd_mux = {30'h0, irq_en, 1'b0};
            OFS_STATUS: rd_mux = {29'h0, aborted, done, busy};
            default:    rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            src_reg         <= 32'h0;
            dst_reg         <= 32'h0;
            len_reg         <= '0;
            irq_en          <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            abort_pend      <= 1'b0;
            src_w           <= 32'h0;
            dst_w           <= 32'h0;
            cnt             <= '0;
            data_buf        <= 32'h0;
            device_rvalid_o <= 1'b0;
            device_rdata_o  <= 32'h0;
        end else begin
            state <= state_nx;
            if (wr_src)  src_reg <= {device_wdata_i[31:2], 2'b00};
            if (wr_dst)  dst_reg <= {device_wdata_i[31:2], 2'b00};
            if (wr_len)  len_reg <= device_wdata_i[LenWidth-1:0];
            if (wr_ctrl) irq_en  <= device_wdata_i[1];

            if (start_cmd) begin
                src_w      <= src_reg;
                dst_w      <= dst_reg;
                cnt        <= len_reg;
                abort_pend <= 1'b0;
            end
            if (abort_cmd)    abort_pend <= 1'b1;
            if (finish_abort) abort_pend <= 1'b0;

            if (rd_capture) data_buf <= resp_rdata_i;
            if (word_done) begin
                src_w <= src_w + 32'd4;
                dst_w <= dst_w + 32'd4;
                cnt   <= cnt - LenWidth'(1);
            end

            // Software clears first so a same-cycle hardware set takes priority.
            if (wr_status && device_wdata_i[1]) done    <= 1'b0;
            if (wr_status && device_wdata_i[2]) aborted <= 1'b0;
            if (start_cmd) begin
                done    <= (len_reg == '0);
                aborted <= 1'b0;
            end
            if (finish_done)  done    <= 1'b1;
            if (finish_abort) aborted <= 1'b1;

            device_rvalid_o <= device_req_i;
            device_rdata_o  <= cfg_rd ? rd_mux : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pinaipple_dma.sv
`default_nettype none
// Directed testbench for pinaipple_dma with a single-outstanding memory responder.
module tb_pinaipple_dma;

    logic        clk_i, rst_i;
    logic        device_req_i, device_we_i, device_rvalid_o;
    logic [11:0] device_addr_i;
    logic [3:0]  device_be_i;
    logic [31:0] device_wdata_i, device_rdata_o;
    logic        req_valid_o, req_ready_i, req_wen_o;
    logic [31:0] req_tgt_addr_o, req_wdata_o;
    logic [3:0]  req_be_o;
    logic        resp_valid_i, resp_ready_o, irq_o;
    logic [31:0] resp_rdata_i;

    pinaipple_dma #(.CfgAddrWidth(12), .LenWidth(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .device_req_i(device_req_i), .device_addr_i(device_addr_i),
        .device_we_i(device_we_i), .device_be_i(device_be_i),
        .device_wdata_i(device_wdata_i), .device_rvalid_o(device_rvalid_o),
        .device_rdata_o(device_rdata_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_tgt_addr_o(req_tgt_addr_o), .req_wen_o(req_wen_o),
        .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_rdata_i(resp_rdata_i), .irq_o(irq_o)
    );

    localparam logic [11:0] A_SRC = 12'h000, A_DST = 12'h004, A_LEN = 12'h008;
    localparam logic [11:0] A_CTRL = 12'h00C, A_STATUS = 12'h010;

    int n_tests = 0, n_fail = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic        log_wen  [$];
    int rd_count = 0, wr_count = 0, valid_seen = 0;
    int stall_read = -1, stall_left = 0;
    logic [31:0] held_addr, owed_data;
    logic owed = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    // Responder: one outstanding transaction, response presented the cycle after the handshake.
    initial begin
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'h0;
        forever begin
            @(negedge clk_i);
            resp_valid_i = 1'b0;
            resp_rdata_i = 32'h0;
            req_ready_i  = 1'b0;
            if (rst_i) begin
                owed = 1'b0;
            end else begin
                if (owed && resp_ready_o) begin
                    resp_valid_i = 1'b1;
                    resp_rdata_i = owed_data;
                    owed = 1'b0;
                end
                if (req_valid_o) begin
                    valid_seen++;
                    if (!req_wen_o && rd_count == stall_read && stall_left > 0) begin
                        if (stall_left == 5) held_addr = req_tgt_addr_o;
                        else check("stall_addr_hold", req_tgt_addr_o, held_addr);
                        stall_left--;
                    end else begin
                        req_ready_i = 1'b1;
                        log_addr.push_back(req_tgt_addr_o);
                        log_wen.push_back(req_wen_o);
                        if (req_wen_o) begin
                            mem[req_tgt_addr_o] = req_wdata_o;
                            wr_count++;
                        end else begin
                            owed_data = rd_model(req_tgt_addr_o);
                            rd_count++;
                        end
                        owed = 1'b1;
                    end
                end
            end
        end
    end

    // Config tasks are entered at a negedge and return at the following negedge.
    task automatic cfg_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        device_req_i   = 1'b1;
        device_we_i    = 1'b1;
        device_addr_i  = a;
        device_be_i    = be;
        device_wdata_i = d;
        @(negedge clk_i);
        device_req_i   = 1'b0;
        device_we_i    = 1'b0;
    endtask

    task automatic cfg_read(input logic [11:0] a, output logic [31:0] d);
        device_req_i  = 1'b1;
        device_we_i   = 1'b0;
        device_addr_i = a;
        device_be_i   = 4'hF;
        @(negedge clk_i);
        device_req_i  = 1'b0;
        check("cfg_rvalid", 32'(device_rvalid_o), 32'h1);
        d = device_rdata_o;
    endtask

    task automatic wait_irq(input int max, output int n);
        n = 0;
        while (!irq_o && n < max) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wen.delete();
        rd_count = 0;
        wr_count = 0;
    endtask

    logic [31:0] rd;
    int n, k;

    initial begin
        rst_i = 1'b1;
        device_req_i = 1'b0; device_we_i = 1'b0; device_addr_i = '0;
        device_be_i = 4'h0; device_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_req_valid", 32'(req_valid_o), 32'h0);
        check("rst_req_wen", 32'(req_wen_o), 32'h0);
        check("rst_req_addr", req_tgt_addr_o, 32'h0);
        check("rst_req_wdata", req_wdata_o, 32'h0);
        check("rst_resp_ready", 32'(resp_ready_o), 32'h0);
        check("rst_rvalid", 32'(device_rvalid_o), 32'h0);
        check("rst_rdata", device_rdata_o, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        cfg_read(A_STATUS, rd); check("rst_status", rd, 32'h0);
        cfg_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        @(negedge clk_i);
        check("rvalid_single", 32'(device_rvalid_o), 32'h0);

        // Register map behaviour.
        cfg_write(A_SRC, 32'h0010_0003, 4'hF);
        check("wr_rvalid", 32'(device_rvalid_o), 32'h1);
        check("wr_rdata_zero", device_rdata_o, 32'h0);
        cfg_read(A_SRC, rd); check("src_low_bits", rd, 32'h0010_0000);
        cfg_write(A_LEN, 32'h0001_2345, 4'hF);
        cfg_read(A_LEN, rd); check("len_trunc", rd, 32'h0000_2345);
        cfg_write(A_LEN, 32'h4, 4'hF);
        cfg_write(A_LEN, 32'h9, 4'h3);
        cfg_read(A_LEN, rd); check("len_partial_be", rd, 32'h4);
        cfg_read(12'h020, rd); check("unmapped_read", rd, 32'h0);
        cfg_write(A_DST, 32'h0010_0100, 4'hF);

        // Basic 4-word copy.
        for (int i = 0; i < 8; i++) mem[32'h0010_0000 + 32'(4*i)] = 32'hC0DE_0000 + 32'(i * 32'h111);
        clear_log();
        cfg_write(A_CTRL, 32'h3, 4'hF);
        check("start_req_valid", 32'(req_valid_o), 32'h1);
        wait_irq(200, n);
        check("copy4_cycles", 32'(n), 32'd16);
        check("copy4_log_len", 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("copy4_rd_addr", log_addr[2*i], 32'h0010_0000 + 32'(4*i));
            check("copy4_rd_wen", 32'(log_wen[2*i]), 32'h0);
            check("copy4_wr_addr", log_addr[2*i+1], 32'h0010_0100 + 32'(4*i));
            check("copy4_wr_wen", 32'(log_wen[2*i+1]), 32'h1);
            check("copy4_data", mem[32'h0010_0100 + 32'(4*i)], 32'hC0DE_0000 + 32'(i * 32'h111));
        end
        cfg_read(A_STATUS, rd); check("copy4_status", rd, 32'h2);
        check("copy4_irq", 32'(irq_o), 32'h1);
        cfg_write(A_STATUS, 32'h2, 4'hF);
        check("w1c_irq", 32'(irq_o), 32'h0);

        // Zero-length transfer.
        cfg_write(A_LEN, 32'h0, 4'hF);
        k = valid_seen;
        cfg_write(A_CTRL, 32'h3, 4'hF);
        check("len0_irq_next", 32'(irq_o), 32'h1);
        repeat (5) @(negedge clk_i);
        check("len0_no_req", 32'(valid_seen), 32'(k));
        cfg_read(A_STATUS, rd); check("len0_status", rd, 32'h2);

        // Stalled second read, LEN=3.
        cfg_write(A_DST, 32'h0010_0200, 4'hF);
        cfg_write(A_LEN, 32'h3, 4'hF);
        clear_log();
        stall_read = 1; stall_left = 5;
        cfg_write(A_CTRL, 32'h3, 4'hF);
        wait_irq(200, n);
        check("stall_cycles", 32'(n), 32'd17);
        check("stall_rd2_addr", log_addr[2], 32'h0010_0004);
        for (int i = 0; i < 3; i++)
            check("stall_data", mem[32'h0010_0200 + 32'(4*i)], 32'hC0DE_0000 + 32'(i * 32'h111));
        stall_read = -1;

        // Writes and START while busy are ignored.
        cfg_write(A_DST, 32'h0010_0300, 4'hF);
        cfg_write(A_LEN, 32'h4, 4'hF);
        clear_log();
        cfg_write(A_CTRL, 32'h3, 4'hF);
        repeat (3) @(negedge clk_i);
        cfg_write(A_SRC, 32'hDEAD_0000, 4'hF);
        cfg_write(A_CTRL, 32'h3, 4'hF);
        cfg_read(A_SRC, rd); check("busy_src_kept", rd, 32'h0010_0000);
        wait_irq(200, n);
        check("busy_rd_count", 32'(rd_count), 32'd4);
        check("busy_last_data", mem[32'h0010_030C], 32'hC0DE_0333);

        // Address wrap at 2^32.
        cfg_write(A_SRC, 32'hFFFF_FFFC, 4'hF);
        cfg_write(A_DST, 32'h0010_0400, 4'hF);
        cfg_write(A_LEN, 32'h2, 4'hF);
        clear_log();
        cfg_write(A_CTRL, 32'h3, 4'hF);
        wait_irq(200, n);
        check("wrap_cycles", 32'(n), 32'd8);
        check("wrap_rd1", log_addr[0], 32'hFFFF_FFFC);
        check("wrap_rd2", log_addr[2], 32'h0000_0000);
        check("wrap_wr2", log_addr[3], 32'h0010_0404);
        check("wrap_data", mem[32'h0010_0404], 32'hFFFF_FFFF);

        // Abort after the third write handshake.
        cfg_write(A_SRC, 32'h0010_0000, 4'hF);
        cfg_write(A_DST, 32'h0010_0500, 4'hF);
        cfg_write(A_LEN, 32'h8, 4'hF);
        clear_log();
        cfg_write(A_CTRL, 32'h3, 4'hF);
        k = 0;
        while (wr_count < 3 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("abort_reach_wr3", 32'(wr_count), 32'd3);
        cfg_write(A_CTRL, 32'h6, 4'hF);
        repeat (10) @(negedge clk_i);
        check("abort_rd_count", 32'(rd_count), 32'd3);
        check("abort_wr_count", 32'(wr_count), 32'd3);
        check("abort_resp_taken", 32'(owed), 32'h0);
        cfg_read(A_STATUS, rd); check("abort_status", rd, 32'h4);
        check("abort_irq", 32'(irq_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
